delivery_sequencer: RTL and testbench

//   Ball-by-ball innings sequencer that drives the over counter. It takes one

---
 rtl/delivery_sequencer.sv | 128 ++++++++++++
 tb/tb_delivery_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/delivery_sequencer.sv
// Ball-by-ball innings sequencer: counts legal deliveries, emits the per-over
// pulse for the over counter, tracks wickets and closes the innings at either limit.
module delivery_sequencer #(
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS      = 20,
  parameter int MAX_WICKETS    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ball_valid,
  input  logic       ball_extra,
  input  logic       ball_wicket,
  input  logic       pause,
  output logic       over_complete,
  output logic [2:0] ball_in_over,
  output logic [4:0] overs_done,
  output logic [3:0] wickets,
  output logic [1:0] state,
  output logic       innings_done,
  output logic       illegal_ball
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] LAST_BALL = 3'(BALLS_PER_OVER - 1);
  localparam logic [4:0] OVER_LIM  = 5'(MAX_OVERS);
  localparam logic [3:0] WKT_LIM   = 4'(MAX_WICKETS);

  state_t     r_state;
  logic [2:0] r_ball;
  logic [4:0] r_overs;
  logic [3:0] r_wkts;
  logic       r_overComplete;
  logic       r_illegal;
  logic       r_done;

  state_t     w_nextState;
  logic [2:0] w_nextBall;
  logic [4:0] w_nextOvers;
  logic [3:0] w_nextWkts;
  logic       w_nextOverComplete;
  logic       w_nextIllegal;

  // Limits are tested on the post-delivery counts so the final ball both
  // updates the counters and closes the innings on the same edge.
  always_comb begin
    w_nextState        = r_state;
    w_nextBall         = r_ball;
    w_nextOvers        = r_overs;
    w_nextWkts         = r_wkts;
    w_nextOverComplete = 1'b0;
    w_nextIllegal      = 1'b0;

    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_nextState = PLAY;
          w_nextBall  = '0;
          w_nextOvers = '0;
          w_nextWkts  = '0;
        end else if (ball_valid) begin
          w_nextIllegal = 1'b1;
        end
      end
      PLAY: begin
        if (ball_valid) begin
          if (ball_wicket) w_nextWkts = r_wkts + 4'd1;
          if (!ball_extra) begin
            if (r_ball == LAST_BALL) begin
              w_nextBall         = '0;
              w_nextOvers        = r_overs + 5'd1;
              w_nextOverComplete = 1'b1;
            end else begin
              w_nextBall = r_ball + 3'd1;
            end
          end
        end
        if (w_nextWkts == WKT_LIM || w_nextOvers == OVER_LIM) begin
          w_nextState = DONE;
        end else if (pause) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (ball_valid) w_nextIllegal = 1'b1;
        if (!pause) w_nextState = PLAY;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_ball         <= '0;
      r_overs        <= '0;
      r_wkts         <= '0;
      r_overComplete <= 1'b0;
      r_illegal      <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_ball         <= w_nextBall;
      r_overs        <= w_nextOvers;
      r_wkts         <= w_nextWkts;
      r_overComplete <= w_nextOverComplete;
      r_illegal      <= w_nextIllegal;
      r_done         <= (w_nextState == DONE);
    end
  end

  assign over_complete = r_overComplete;
  assign ball_in_over  = r_ball;
  assign overs_done    = r_overs;
  assign wickets       = r_wkts;
  assign state         = r_state;
  assign innings_done  = r_done;
  assign illegal_ball  = r_illegal;

endmodule

// File: tb/tb_delivery_sequencer.sv
// Bench for delivery_sequencer: directed innings scenarios followed by random
// play, each cycle compared with a total-legal-ball reference model.
module tb_delivery_sequencer;

  localparam int BPO = 6;
  localparam int MO  = 2;
  localparam int MW  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ballValid;
  logic       ballExtra;
  logic       ballWicket;
  logic       pause;
  logic       overComplete;
  logic [2:0] ballInOver;
  logic [4:0] oversDone;
  logic [3:0] wickets;
  logic [1:0] state;
  logic       inningsDone;
  logic       illegalBall;

  int checks = 0;
  int errors = 0;

  // Reference model: innings described by total legal balls and wickets.
  int mState;
  int mLegal;
  int mWk;
  bit mOc;
  bit mIll;

  delivery_sequencer #(
    .BALLS_PER_OVER(BPO),
    .MAX_OVERS     (MO),
    .MAX_WICKETS   (MW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ball_valid   (ballValid),
    .ball_extra   (ballExtra),
    .ball_wicket  (ballWicket),
    .pause        (pause),
    .over_complete(overComplete),
    .ball_in_over (ballInOver),
    .overs_done   (oversDone),
    .wickets      (wickets),
    .state        (state),
    .innings_done (inningsDone),
    .illegal_ball (illegalBall)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string step);
    checkVal({step, ".state"},        8'(state),        8'(mState));
    checkVal({step, ".ball_in_over"}, 8'(ballInOver),   8'(mLegal % BPO));
    checkVal({step, ".overs_done"},   8'(oversDone),    8'(mLegal / BPO));
    checkVal({step, ".wickets"},      8'(wickets),      8'(mWk));
    checkVal({step, ".over_complete"},8'(overComplete), 8'(mOc));
    checkVal({step, ".innings_done"}, 8'(inningsDone),  8'(mState == 3));
    checkVal({step, ".illegal_ball"}, 8'(illegalBall),  8'(mIll));
  endtask

  task automatic modelReset();
    mState = 0;
    mLegal = 0;
    mWk    = 0;
    mOc    = 1'b0;
    mIll   = 1'b0;
  endtask

  task automatic modelStep(input bit s, input bit v, input bit e, input bit w, input bit p);
    mOc  = 1'b0;
    mIll = 1'b0;
    case (mState)
      0, 3: begin
        if (s) begin
          mState = 1;
          mLegal = 0;
          mWk    = 0;
        end else if (v) begin
          mIll = 1'b1;
        end
      end
      1: begin
        if (v) begin
          if (w) mWk++;
          if (!e) begin
            mLegal++;
            if (mLegal % BPO == 0) mOc = 1'b1;
          end
        end
        if (mWk == MW || mLegal / BPO == MO) mState = 3;
        else if (p) mState = 2;
      end
      default: begin
        if (v) mIll = 1'b1;
        if (!p) mState = 1;
      end
    endcase
  endtask

  task automatic applyStimulus(input string step, input bit s, input bit v, input bit e,
                               input bit w, input bit p);
    start      = s;
    ballValid  = v;
    ballExtra  = e;
    ballWicket = w;
    pause      = p;
    modelStep(s, v, e, w, p);
    @(posedge clk);
    #1;
    start      = 1'b0;
    ballValid  = 1'b0;
    ballExtra  = 1'b0;
    ballWicket = 1'b0;
    pause      = 1'b0;
    checkOutput(step);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    ballValid  = 1'b0;
    ballExtra  = 1'b0;
    ballWicket = 1'b0;
    pause      = 1'b0;
    modelReset();
    #3;
    checkOutput("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("resetRelease");

    applyStimulus("idleBall", 0, 1, 1'($urandom % 2), 1'($urandom % 2), 0);
    applyStimulus("start", 1, 0, 0, 0, 0);

    // One clean over with random idle gaps carrying don't-care qualifiers.
    for (int i = 0; i < 6; i++) begin
      applyStimulus("t1Ball", 0, 1, 0, 0, 0);
      if ($urandom % 2 == 1) applyStimulus("t1Gap", 0, 0, 1'($urandom % 2), 1'($urandom % 2), 0);
    end

    // Second over with two wides; completing it reaches the over limit.
    applyStimulus("t2Wide", 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("t2Ball", 0, 1, 0, 0, 0);
    applyStimulus("t2Wide", 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("t2Ball", 0, 1, 0, 0, 0);

    applyStimulus("t3Ball13", 0, 1, 0, 0, 0);
    applyStimulus("t3StartPriority", 1, 1, 0, 1, 0);

    // Wicket limit mid-over via run-outs on wides.
    for (int i = 0; i < 3; i++) applyStimulus("t4Ball", 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus("t4Wicket", 0, 1, 1, 1, 0);
    applyStimulus("t4DoneBall", 0, 1, 0, 1, 0);

    // Both limits on the same delivery.
    applyStimulus("t4Restart", 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus("t4bWicket", 0, 1, 1, 1, 0);
    for (int i = 0; i < 11; i++) applyStimulus("t4bBall", 0, 1, 0, 0, 0);
    applyStimulus("t4bLastBall", 0, 1, 0, 1, 0);

    // Pause handling.
    applyStimulus("t5Restart", 1, 0, 0, 0, 0);
    applyStimulus("t5Ball", 0, 1, 0, 0, 0);
    applyStimulus("t5Ball", 0, 1, 0, 0, 0);
    applyStimulus("t5PauseBall", 0, 1, 0, 0, 1);
    applyStimulus("t5HoldBall", 0, 1, 0, 1, 1);
    applyStimulus("t5HoldStart", 1, 0, 0, 0, 1);
    applyStimulus("t5Resume", 0, 0, 0, 0, 0);
    applyStimulus("t5PauseIdle", 0, 0, 0, 0, 1);
    applyStimulus("t5Resume2", 0, 0, 0, 0, 0);

    // Asynchronous reset between edges, then a fresh innings.
    applyStimulus("t6Ball", 0, 1, 0, 1, 0);
    #3;
    reset = 1'b1;
    #2;
    modelReset();
    checkOutput("t6AsyncReset");
    #1;
    reset = 1'b0;
    applyStimulus("t6Start", 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("t6Ball", 0, 1, 0, 0, 0);

    // Random play.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom % 30) == 0,
                    1'($urandom % 2),
                    ($urandom % 4) == 0,
                    ($urandom % 6) == 0,
                    ($urandom % 10) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
